// File: rtl/uart_rx_apb.sv
// UART receiver with APB register access and a receive FIFO.
// Sticky error reporting, programmable baud divisor, optional parity and second stop bit.
module uart_rx_apb #(
  parameter int          DATA_BITS   = 8,
  parameter int          OVERSAMPLE  = 16,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd53
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_in,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        rx_irq
);

  localparam int DW = (DATA_BITS > 8) ? DATA_BITS : 8;
  localparam int WW = DW + 2;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [4:0]  ctrl;
  logic [15:0] bauddiv, div_cur, baud_cnt;
  logic        rx_en, par_en, par_odd, two_stop, irq_en;
  logic        access, aligned, wr_en, rd_en;
  logic [1:0]  reg_sel;
  logic        rx_m, rx_s, tick;
  logic [2:0]  state;
  logic [TW-1:0] tick_cnt;
  logic [3:0]  bit_cnt;
  logic        second, perr, ferr;
  logic        sample_half, sample_full, stop_last;
  logic [DATA_BITS-1:0] shift;
  logic [WW-1:0] word_p1;
  logic        vld_p1;
  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic        not_empty, full, pop, accept;
  logic        ovr_s, perr_s, ferr_s;
  logic        unused_pwdata;

  assign rx_en    = ctrl[0];
  assign par_en   = (ctrl[2:1] == 2'b01) || (ctrl[2:1] == 2'b10);
  assign par_odd  = (ctrl[2:1] == 2'b10);
  assign two_stop = ctrl[3];
  assign irq_en   = ctrl[4];

  assign access  = psel & penable;
  assign aligned = (paddr[1:0] == 2'b00);
  assign wr_en   = access & pwrite & aligned;
  assign rd_en   = access & ~pwrite & aligned;
  assign reg_sel = paddr[3:2];
  assign pready  = access;
  assign pslverr = access & ~aligned;
  assign unused_pwdata = ^pwdata[31:16];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
    end
  end

  // A divisor write is picked up only when the counter wraps or is idle.
  assign tick = rx_en && (baud_cnt == div_cur);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt <= '0;
      div_cur  <= DEFAULT_DIV;
    end else if (!rx_en || tick) begin
      baud_cnt <= '0;
      div_cur  <= bauddiv;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  assign sample_half = tick && (tick_cnt == TW'(OVERSAMPLE / 2 - 1));
  assign sample_full = tick && (tick_cnt == TW'(OVERSAMPLE - 1));
  assign stop_last   = (state == STOP) && sample_full && (!two_stop || second);

  // Stage p0: receiver FSM on the synchronised line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      second   <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= stop_last;
      if (!rx_en) begin
        state    <= IDLE;
        tick_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (!rx_s) begin
            state    <= START;
            tick_cnt <= '0;
          end
          START: if (sample_half) begin
            if (rx_s) state <= IDLE;
            else begin
              state    <= DATA;
              tick_cnt <= '0;
              bit_cnt  <= '0;
            end
          end else if (tick) tick_cnt <= tick_cnt + 1'b1;
          DATA: if (sample_full) begin
            tick_cnt <= '0;
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
              perr   <= 1'b0;
              ferr   <= 1'b0;
              second <= 1'b0;
              state  <= par_en ? PARITY : STOP;
            end
          end else if (tick) tick_cnt <= tick_cnt + 1'b1;
          PARITY: if (sample_full) begin
            tick_cnt <= '0;
            perr     <= rx_s ^ (^shift) ^ par_odd;
            state    <= STOP;
          end else if (tick) tick_cnt <= tick_cnt + 1'b1;
          STOP: if (sample_full) begin
            tick_cnt <= '0;
            ferr     <= ferr | ~rx_s;
            second   <= 1'b1;
            if (!two_stop || second) state <= IDLE;
          end else if (tick) tick_cnt <= tick_cnt + 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state == DATA) && sample_full) shift <= {rx_s, shift[DATA_BITS-1:1]};
    if (stop_last) word_p1 <= {ferr | ~rx_s, perr, DW'(shift)};
  end

  // Stage p1: FIFO push of the completed frame, APB pops
  assign not_empty = (count != '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign pop       = rd_en && (reg_sel == 2'd0) && not_empty;
  assign accept    = vld_p1 && (!full || pop);

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= word_p1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovr_s   <= 1'b0;
      perr_s  <= 1'b0;
      ferr_s  <= 1'b0;
      ctrl    <= '0;
      bauddiv <= DEFAULT_DIV;
      rx_irq  <= 1'b0;
    end else begin
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      count <= count + CW'(accept) - CW'(pop);
      if (wr_en && reg_sel == 2'd1) begin
        if (pwdata[2]) ovr_s  <= 1'b0;
        if (pwdata[3]) perr_s <= 1'b0;
        if (pwdata[4]) ferr_s <= 1'b0;
      end
      // Setting wins over a simultaneous W1C so no event is lost.
      if (vld_p1 && full && !pop)    ovr_s  <= 1'b1;
      if (accept && word_p1[WW-2])   perr_s <= 1'b1;
      if (accept && word_p1[WW-1])   ferr_s <= 1'b1;
      if (wr_en && reg_sel == 2'd2) ctrl    <= pwdata[4:0];
      if (wr_en && reg_sel == 2'd3) bauddiv <= pwdata[15:0];
      rx_irq <= irq_en & (not_empty | ovr_s | perr_s | ferr_s);
    end
  end

  always_comb begin
    prdata = '0;
    if (rd_en) begin
      case (reg_sel)
        2'd0:    if (not_empty) prdata = 32'(mem[rd_ptr]);
        2'd1:    prdata = {27'b0, ferr_s, perr_s, ovr_s, full, not_empty};
        2'd2:    prdata = {27'b0, ctrl};
        default: prdata = {16'b0, bauddiv};
      endcase
    end
  end

endmodule
